// File: rtl/shift_sequencer.sv
// Multi-cycle controller that runs wide shift counts through an external 8-bit shifter in chunks of up to 7.
// Optional macro SHIFT_SEQ_ROT_MOD_EN: rotates load count mod 8, finishing in at most one RUN cycle.
module shift_sequencer #(
    parameter int COUNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [7:0]         cmd_data,
    input  logic [COUNT_W-1:0] cmd_count,
    output logic [7:0]         sh_din,
    output logic [2:0]         sh_sel,
    output logic [2:0]         sh_shift_count,
    input  logic [7:0]         sh_dout,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [7:0]         rsp_data,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_PASS0 = 3'd0;
    localparam logic [2:0] OP_ROL   = 3'd5;
    localparam logic [2:0] OP_ROR   = 3'd6;
    localparam logic [2:0] OP_PASS7 = 3'd7;

    localparam logic [COUNT_W-1:0] MAX_CHUNK = COUNT_W'(7);

    state_t             state, state_nxt;
    logic [7:0]         acc, acc_nxt;
    logic [2:0]         op, op_nxt;
    logic [COUNT_W-1:0] rem, rem_nxt;
    logic [COUNT_W-1:0] load_count;
    logic [2:0]         chunk;
    logic               accept;
    logic               load_is_pass;

    // cmd_ready is only ever high in IDLE, so it alone qualifies the handshake.
    assign accept       = cmd_valid && cmd_ready;
    assign load_is_pass = (cmd_op == OP_PASS0) || (cmd_op == OP_PASS7);
    assign chunk        = (rem > MAX_CHUNK) ? 3'd7 : rem[2:0];

`ifdef SHIFT_SEQ_ROT_MOD_EN
    // Rotating by 8 is the identity, so only the low three bits matter.
    assign load_count = ((cmd_op == OP_ROL) || (cmd_op == OP_ROR))
                      ? COUNT_W'(cmd_count[2:0]) : cmd_count;
`else
    assign load_count = cmd_count;
`endif

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        op_nxt         = op;
        rem_nxt        = rem;
        sh_sel         = 3'd0;
        sh_shift_count = 3'd0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    acc_nxt = cmd_data;
                    op_nxt  = cmd_op;
                    rem_nxt = load_count;
                    if (load_is_pass || (load_count == '0)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                sh_sel         = op;
                sh_shift_count = chunk;
                acc_nxt        = sh_dout;
                rem_nxt        = rem - COUNT_W'(chunk);
                if (rem <= MAX_CHUNK) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= 8'h00;
            op        <= 3'd0;
            rem       <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            op        <= op_nxt;
            rem       <= rem_nxt;
            cmd_ready <= (state_nxt == S_IDLE);
            rsp_valid <= (state_nxt == S_DONE);
            busy      <= (state_nxt != S_IDLE);
        end
    end

    // acc only changes in IDLE-accept and RUN, so it is stable throughout DONE.
    assign sh_din   = acc;
    assign rsp_data = acc;

endmodule
